// File: rtl/pmod_keypad_scan_ctrl.sv
// pmod_keypad_scan_ctrl
//   Column-strobe scanner for a 4x4 matrix keypad. Each column is driven low
//   for SETTLE_CYCLES, then its synchronized rows are sampled. A completed
//   4-column frame is reduced to a single key / none / multi-key result,
//   debounced over DEBOUNCE_FRAMES identical frames, and each accepted press
//   is presented as one event on a valid/ready handshake.
//   Optional build macro: KEYPAD_RELEASE_EVT_EN -- when defined, releases are
//   reported as events too (key_rel=1); otherwise key_rel is tied low.
module pmod_keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_rel,
  input  logic       key_ready,
  output logic       key_pressed,
  output logic       multi_key,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int               DB_W        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_FULL     = DB_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [1:0]       col_idx;

  // row_p0/row_p1: two-flop synchronizer stages for the asynchronous rows
  logic [3:0]       row_p0;
  logic [3:0]       row_p1;

  // Per-column hit bits (bit r set = row r pulled low) for the current frame
  logic [3:0]       col_hits [4];

  // Debounce candidate and accepted (debounced) state; *_none marks NONE
  logic             cand_none;
  logic [3:0]       cand_code;
  logic [DB_W-1:0]  cand_cnt;
  logic             acc_none;
  logic [3:0]       acc_code;

  // Frame evaluation / event generation (combinational)
  logic [3:0]       hits_now [4];
  logic [15:0]      frame_keys;
  logic [4:0]       frame_ones;
  logic             res_none;
  logic [3:0]       res_code;
  logic             same_cand;
  logic [DB_W-1:0]  cnt_next;
  logic             settled;
  logic             frame_done;
  logic             ev_fire;
  logic [3:0]       ev_code;
  logic             acc_none_next;
  logic [3:0]       acc_code_next;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic             ev_rel;
`endif
  logic             drop_ev;
  logic             load_ev;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0000, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Synchronize the raw rows; reset to the released (pulled-up) level
  always_ff @(posedge clk) begin
    if (rst) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row_n;
      row_p1 <= row_p0;
    end
  end

  // Assemble the frame including the column being sampled now, classify it,
  // and work out the debounce update and any event it produces
  always_comb begin
    for (int c = 0; c < 4; c++) hits_now[c] = col_hits[c];
    hits_now[col_idx] = ~row_p1;
    frame_keys = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        frame_keys[r*4 + c] = hits_now[c][r];
    frame_ones = popcount16(frame_keys);
    res_none   = (frame_ones != 5'd1);
    res_code   = lowest_index(frame_keys);
    same_cand  = (res_none == cand_none) && (res_none || (res_code == cand_code));
    if (!same_cand)              cnt_next = DB_W'(1);
    else if (cand_cnt == DB_FULL) cnt_next = cand_cnt;
    else                          cnt_next = cand_cnt + 1'b1;
    settled    = (cnt_next == DB_FULL) &&
                 ((res_none != acc_none) || (!res_none && (res_code != acc_code)));
    frame_done = enable && (state == SAMPLE) && (col_idx == 2'd3);

    ev_fire       = 1'b0;
    ev_code       = res_code;
    acc_none_next = acc_none;
    acc_code_next = acc_code;
`ifdef KEYPAD_RELEASE_EVT_EN
    ev_rel        = 1'b0;
`endif
    if (frame_done && settled) begin
`ifdef KEYPAD_RELEASE_EVT_EN
      if (res_none || !acc_none) begin
        // Release of the held key. For a code-to-code change the candidate
        // stays saturated, so the new press fires on the next frame.
        acc_none_next = 1'b1;
        ev_fire       = 1'b1;
        ev_rel        = 1'b1;
        ev_code       = acc_code;
      end else begin
        acc_none_next = 1'b0;
        acc_code_next = res_code;
        ev_fire       = 1'b1;
      end
`else
      if (res_none) begin
        acc_none_next = 1'b1;
      end else begin
        // Covers both a fresh press and a code-to-code change
        acc_none_next = 1'b0;
        acc_code_next = res_code;
        ev_fire       = 1'b1;
      end
`endif
    end
  end

  // Scan sequencer plus frame/debounce state, updated on the last column
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col_n      <= 4'hF;
      col_idx    <= '0;
      settle_cnt <= '0;
      for (int c = 0; c < 4; c++) col_hits[c] <= '0;
      cand_none  <= 1'b1;
      cand_code  <= '0;
      cand_cnt   <= '0;
      acc_none   <= 1'b1;
      acc_code   <= '0;
      multi_key  <= 1'b0;
    end else if (!enable) begin
      // Stop scanning; the accepted state survives, the partial frame does not
      state      <= IDLE;
      col_n      <= 4'hF;
      col_idx    <= '0;
      settle_cnt <= '0;
      for (int c = 0; c < 4; c++) col_hits[c] <= '0;
      cand_none  <= 1'b1;
      cand_code  <= '0;
      cand_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state      <= DRIVE;
          col_idx    <= '0;
          col_n      <= 4'hE;
          settle_cnt <= '0;
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        SAMPLE: begin
          col_hits[col_idx] <= ~row_p1;
          col_idx           <= col_idx + 2'd1;
          col_n             <= ~(4'b0001 << (col_idx + 2'd1));
          settle_cnt        <= '0;
          state             <= DRIVE;
          if (col_idx == 2'd3) begin
            cand_none <= res_none;
            cand_code <= res_code;
            cand_cnt  <= cnt_next;
            acc_none  <= acc_none_next;
            acc_code  <= acc_code_next;
            multi_key <= (frame_ones > 5'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_pressed = ~acc_none;

  // An event arriving while the previous one is stalled is lost
  assign drop_ev = ev_fire && key_valid && !key_ready;
  assign load_ev = ev_fire && !drop_ev;

  // Event handshake register and sticky overrun flag (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load_ev) begin
        key_valid <= 1'b1;
        key_code  <= ev_code;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (drop_ev)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  // Release flag travels with the event code
  always_ff @(posedge clk) begin
    if (rst)          key_rel <= 1'b0;
    else if (load_ev) key_rel <= ev_rel;
  end
`else
  assign key_rel = 1'b0;
`endif

endmodule
